// File: rtl/hazard_pkg.sv
// Shared types and parameter checks for the hazard scoreboard.
// Scoreboard addresses are stored at a fixed width so that one struct serves every NREGS.
package hazard_pkg;

  localparam int SB_AW       = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] addr;
    logic             is_load;
  } sb_entry_t;

  function automatic bit params_legal(input int nregs, input int aw, input int depth,
                                      input int nsrc, input int load_stage);
    return (depth >= 2) && (depth <= 7) &&
           (load_stage >= 2) && (load_stage <= depth) &&
           (nsrc >= 1) && (nregs >= 2) && (nregs <= (1 << SB_AW)) &&
           ((1 << aw) >= nregs);
  endfunction

endpackage

// File: rtl/sb_match.sv
// Per-source scoreboard lookup: finds the youngest in-flight writer of the operand
// and decides whether its result can be forwarded yet or the instruction must wait.
module sb_match
  import hazard_pkg::*;
#(
  parameter int NREGS      = 16,
  parameter int AW         = $clog2(NREGS),
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 3,
  parameter int FW         = $clog2(DEPTH + 1)
) (
  input  logic                   i_valid,
  input  logic                   i_used,
  input  logic [AW-1:0]          i_addr,
  input  sb_entry_t [DEPTH-1:1]  i_entries,
  output logic                   o_stall,
  output logic [FW-1:0]          o_sel
);

  logic w_check;
  logic w_found;

  // The PC is supplied by the fetch path, never by the scoreboard.
  assign w_check = i_valid & i_used & (i_addr != AW'(NREGS - 1));

  always_comb begin
    o_stall = 1'b0;
    o_sel   = FW'(FWD_REGFILE);
    w_found = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if (w_check && !w_found && i_entries[k].valid &&
          i_entries[k].addr == SB_AW'(i_addr)) begin
        w_found = 1'b1;
        if (k + 1 >= (i_entries[k].is_load ? LOAD_STAGE : 2)) begin
          o_sel = FW'(k + 1);
        end else begin
          o_stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: shift-register scoreboard of in-flight writes,
// stall/flush generation for F/D/E, registered E-stage forward selects and a stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS      = 16,
  parameter int AW         = $clog2(NREGS),
  parameter int DEPTH      = 3,
  parameter int NSRC       = 3,
  parameter int LOAD_STAGE = 3,
  parameter int CNT_W      = 32,
  localparam int FW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 d_valid,
  input  logic [NSRC*AW-1:0]   d_src_addr,
  input  logic [NSRC-1:0]      d_src_used,
  input  logic                 d_wr_en,
  input  logic [AW-1:0]        d_wr_addr,
  input  logic                 d_is_load,
  input  logic                 e_cond_fail,
  input  logic                 branch_taken_e,
  output logic                 stall_f,
  output logic                 stall_d,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic [NSRC*FW-1:0]   fwd_sel_e,
  output logic [CNT_W-1:0]     stall_count
);

  if (!params_legal(NREGS, AW, DEPTH, NSRC, LOAD_STAGE)) begin : g_illegal_params
    $error("hazard_scoreboard: illegal parameter set");
  end

  sb_entry_t [DEPTH:1]  r_sb;
  sb_entry_t            w_entry1;
  sb_entry_t            w_entry2;
  logic [NSRC-1:0]      w_src_stall;
  logic [NSRC*FW-1:0]   w_next_sel;
  logic [NSRC*FW-1:0]   r_fwd_sel;
  logic [CNT_W-1:0]     r_stall_count;
  logic [SB_AW-1:0]     w_pc_addr;
  logic                 w_data_stall;
  logic                 w_d_pc_wr;
  logic                 w_sb_pc_wr;
  logic                 w_pc_wr_pending;
  logic                 w_pc_wr_w;
  logic                 w_unused;

  assign w_pc_addr = SB_AW'(NREGS - 1);

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      sb_match #(
        .NREGS      (NREGS),
        .AW         (AW),
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LOAD_STAGE),
        .FW         (FW)
      ) u_match (
        .i_valid   (d_valid),
        .i_used    (d_src_used[gi]),
        .i_addr    (d_src_addr[gi*AW +: AW]),
        .i_entries (r_sb[DEPTH-1:1]),
        .o_stall   (w_src_stall[gi]),
        .o_sel     (w_next_sel[gi*FW +: FW])
      );
    end
  endgenerate

  assign w_data_stall = |w_src_stall;

  assign w_d_pc_wr = d_valid & d_wr_en & (d_wr_addr == AW'(NREGS - 1));

  always_comb begin
    w_sb_pc_wr = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if (r_sb[k].valid && r_sb[k].addr == w_pc_addr) begin
        w_sb_pc_wr = 1'b1;
      end
    end
  end

  assign w_pc_wr_pending = w_d_pc_wr | w_sb_pc_wr;
  assign w_pc_wr_w       = r_sb[DEPTH].valid & (r_sb[DEPTH].addr == w_pc_addr);

  // A taken branch discards D, so it overrides holding D for a data stall.
  assign stall_f = w_data_stall | w_pc_wr_pending;
  assign stall_d = w_data_stall & ~branch_taken_e;
  assign flush_e = w_data_stall | branch_taken_e;
  assign flush_d = branch_taken_e | (~w_data_stall & (w_pc_wr_pending | w_pc_wr_w));

  always_comb begin
    w_entry1 = '0;
    if (!flush_e) begin
      w_entry1.valid   = d_valid & d_wr_en;
      w_entry1.addr    = SB_AW'(d_wr_addr);
      w_entry1.is_load = d_is_load;
    end
    // A condition-failed E instruction never writes, so it stops being a hazard.
    w_entry2       = r_sb[1];
    w_entry2.valid = r_sb[1].valid & ~e_cond_fail;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb          <= '0;
      r_fwd_sel     <= '0;
      r_stall_count <= '0;
    end else begin
      r_sb[1] <= w_entry1;
      r_sb[2] <= w_entry2;
      for (int k = 3; k <= DEPTH; k++) begin
        r_sb[k] <= r_sb[k-1];
      end
      r_fwd_sel <= flush_e ? '0 : w_next_sel;
      if (stall_d && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign fwd_sel_e   = r_fwd_sel;
  assign stall_count = r_stall_count;

  // The write-back stage's load flag has no consumer.
  assign w_unused = r_sb[DEPTH].is_load;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized
// traffic compared against an in-flight-write list model.
module tb_hazard_scoreboard;

  localparam int TB_DEPTH = 3;
  localparam int TB_LS    = 3;
  localparam int PC_REG   = 15;

  typedef struct {
    int stage;
    int addr;
    bit ld;
  } rec_t;

  logic        clk;
  logic        rst;
  logic        d_valid;
  logic [11:0] d_src_addr;
  logic [2:0]  d_src_used;
  logic        d_wr_en;
  logic [3:0]  d_wr_addr;
  logic        d_is_load;
  logic        e_cond_fail;
  logic        branch_taken_e;

  logic        a_stall_f, a_stall_d, a_flush_d, a_flush_e;
  logic [5:0]  a_fwd;
  logic [31:0] a_cnt;
  logic        b_stall_f, b_stall_d, b_flush_d, b_flush_e;
  logic [8:0]  b_fwd;
  logic [31:0] b_cnt;

  int total;
  int bad;

  hazard_scoreboard u_dut_a (
    .clk            (clk),
    .rst            (rst),
    .d_valid        (d_valid),
    .d_src_addr     (d_src_addr),
    .d_src_used     (d_src_used),
    .d_wr_en        (d_wr_en),
    .d_wr_addr      (d_wr_addr),
    .d_is_load      (d_is_load),
    .e_cond_fail    (e_cond_fail),
    .branch_taken_e (branch_taken_e),
    .stall_f        (a_stall_f),
    .stall_d        (a_stall_d),
    .flush_d        (a_flush_d),
    .flush_e        (a_flush_e),
    .fwd_sel_e      (a_fwd),
    .stall_count    (a_cnt)
  );

  hazard_scoreboard #(.DEPTH(4), .LOAD_STAGE(4)) u_dut_b (
    .clk            (clk),
    .rst            (rst),
    .d_valid        (d_valid),
    .d_src_addr     (d_src_addr),
    .d_src_used     (d_src_used),
    .d_wr_en        (d_wr_en),
    .d_wr_addr      (d_wr_addr),
    .d_is_load      (d_is_load),
    .e_cond_fail    (e_cond_fail),
    .branch_taken_e (branch_taken_e),
    .stall_f        (b_stall_f),
    .stall_d        (b_stall_d),
    .flush_d        (b_flush_d),
    .flush_e        (b_flush_e),
    .fwd_sel_e      (b_fwd),
    .stall_count    (b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    d_valid    = 1'b0;
    d_src_addr = '0;
    d_src_used = '0;
    d_wr_en    = 1'b0;
    d_wr_addr  = '0;
    d_is_load  = 1'b0;
  endtask

  task automatic set_instr(input int wa, input bit we, input bit ld, input int s0,
                           input logic [2:0] used);
    d_valid    = 1'b1;
    d_src_addr = {8'h00, 4'(s0)};
    d_src_used = used;
    d_wr_en    = we;
    d_wr_addr  = 4'(wa);
    d_is_load  = ld;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    e_cond_fail    = 1'b0;
    branch_taken_e = 1'b0;
    set_nop();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    #1;
    total++;
    if ({a_stall_f, a_stall_d, a_flush_d, a_flush_e} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl_a got=%b exp=0000", {a_stall_f, a_stall_d, a_flush_d, a_flush_e});
    end
    total++;
    if ({b_stall_f, b_stall_d, b_flush_d, b_flush_e} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl_b got=%b exp=0000", {b_stall_f, b_stall_d, b_flush_d, b_flush_e});
    end
    total++;
    if (a_fwd !== 6'd0 || a_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_regs_a fwd=%0d cnt=%0d exp=0/0", a_fwd, a_cnt);
    end
    total++;
    if (b_fwd !== 9'd0 || b_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_regs_b fwd=%0d cnt=%0d exp=0/0", b_fwd, b_cnt);
    end
    $display("reset checked");
  endtask

  task automatic test_forward();
    do_reset();
    set_instr(1, 1, 0, 0, 3'b000);
    #1;
    total++;
    if (a_stall_f !== 1'b0) begin bad++; $display("FAIL fwd1_add_stall got=%b exp=0", a_stall_f); end
    tick();
    set_instr(4, 1, 0, 1, 3'b001);
    #1;
    total++;
    if (a_stall_d !== 1'b0 || a_flush_e !== 1'b0) begin
      bad++; $display("FAIL fwd1_sub_stall got=%b%b exp=00", a_stall_d, a_flush_e);
    end
    tick();
    set_nop();
    #1;
    total++;
    if (a_fwd[1:0] !== 2'd2) begin bad++; $display("FAIL fwd1_sel got=%0d exp=2", a_fwd[1:0]); end
    $display("forward back-to-back sel=%0d", a_fwd[1:0]);

    do_reset();
    set_instr(1, 1, 0, 0, 3'b000);
    tick();
    set_nop();
    tick();
    set_instr(4, 1, 0, 1, 3'b001);
    tick();
    set_nop();
    #1;
    total++;
    if (a_fwd[1:0] !== 2'd3) begin bad++; $display("FAIL fwd_gap1_sel got=%0d exp=3", a_fwd[1:0]); end
    $display("forward one-gap sel=%0d", a_fwd[1:0]);

    do_reset();
    set_instr(1, 1, 0, 0, 3'b000);
    tick();
    set_nop();
    tick();
    tick();
    set_instr(4, 1, 0, 1, 3'b001);
    tick();
    set_nop();
    #1;
    total++;
    if (a_fwd[1:0] !== 2'd0) begin bad++; $display("FAIL fwd_gap2_sel got=%0d exp=0", a_fwd[1:0]); end
    $display("forward two-gap sel=%0d", a_fwd[1:0]);
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(2, 1, 1, 0, 3'b000);
    tick();
    set_instr(5, 1, 0, 2, 3'b001);
    #1;
    total++;
    if ({a_stall_f, a_stall_d, a_flush_e} !== 3'b111) begin
      bad++; $display("FAIL ldu_a_c1 got=%b exp=111", {a_stall_f, a_stall_d, a_flush_e});
    end
    total++;
    if ({b_stall_f, b_stall_d, b_flush_e} !== 3'b111) begin
      bad++; $display("FAIL ldu_b_c1 got=%b exp=111", {b_stall_f, b_stall_d, b_flush_e});
    end
    tick();
    #1;
    total++;
    if (a_stall_d !== 1'b0) begin bad++; $display("FAIL ldu_a_c2 got=%b exp=0", a_stall_d); end
    total++;
    if (b_stall_d !== 1'b1) begin bad++; $display("FAIL ldu_b_c2 got=%b exp=1", b_stall_d); end
    tick();
    #1;
    total++;
    if (a_fwd[1:0] !== 2'd3) begin bad++; $display("FAIL ldu_a_sel got=%0d exp=3", a_fwd[1:0]); end
    total++;
    if (a_cnt !== 32'd1) begin bad++; $display("FAIL ldu_a_cnt got=%0d exp=1", a_cnt); end
    total++;
    if (b_stall_d !== 1'b0) begin bad++; $display("FAIL ldu_b_c3 got=%b exp=0", b_stall_d); end
    tick();
    set_nop();
    #1;
    total++;
    if (b_fwd[2:0] !== 3'd4) begin bad++; $display("FAIL ldu_b_sel got=%0d exp=4", b_fwd[2:0]); end
    total++;
    if (b_cnt !== 32'd2) begin bad++; $display("FAIL ldu_b_cnt got=%0d exp=2", b_cnt); end
    $display("load-use a_cnt=%0d b_cnt=%0d", a_cnt, b_cnt);
  endtask

  task automatic test_cond_fail();
    do_reset();
    set_instr(3, 1, 0, 0, 3'b000);
    tick();
    set_nop();
    e_cond_fail = 1'b1;
    tick();
    e_cond_fail = 1'b0;
    set_instr(6, 1, 0, 3, 3'b001);
    #1;
    total++;
    if (a_stall_d !== 1'b0) begin bad++; $display("FAIL cond_stall got=%b exp=0", a_stall_d); end
    tick();
    set_nop();
    #1;
    total++;
    if (a_fwd[1:0] !== 2'd0) begin bad++; $display("FAIL cond_sel got=%0d exp=0", a_fwd[1:0]); end
    $display("cond-fail sel=%0d", a_fwd[1:0]);

    do_reset();
    set_instr(PC_REG, 1, 0, 0, 3'b000);
    tick();
    set_instr(6, 1, 0, PC_REG, 3'b001);
    #1;
    total++;
    if ({a_stall_d, a_flush_d, a_flush_e} !== 3'b010) begin
      bad++; $display("FAIL pcread_ctrl got=%b exp=010", {a_stall_d, a_flush_d, a_flush_e});
    end
    tick();
    set_nop();
    #1;
    total++;
    if (a_fwd[1:0] !== 2'd0) begin bad++; $display("FAIL pcread_sel got=%0d exp=0", a_fwd[1:0]); end
    $display("pc-read sel=%0d", a_fwd[1:0]);
  endtask

  task automatic test_branch_vs_stall();
    do_reset();
    set_instr(2, 1, 1, 0, 3'b000);
    tick();
    set_instr(5, 1, 0, 2, 3'b001);
    branch_taken_e = 1'b1;
    #1;
    total++;
    if ({a_flush_d, a_flush_e, a_stall_d, a_stall_f} !== 4'b1101) begin
      bad++; $display("FAIL br_ctrl_a got=%b exp=1101", {a_flush_d, a_flush_e, a_stall_d, a_stall_f});
    end
    total++;
    if ({b_flush_d, b_stall_d} !== 2'b10) begin
      bad++; $display("FAIL br_ctrl_b got=%b exp=10", {b_flush_d, b_stall_d});
    end
    tick();
    branch_taken_e = 1'b0;
    set_nop();
    #1;
    total++;
    if (a_cnt !== 32'd0 || b_cnt !== 32'd0) begin
      bad++; $display("FAIL br_cnt got=%0d/%0d exp=0/0", a_cnt, b_cnt);
    end
    total++;
    if (a_fwd !== 6'd0) begin bad++; $display("FAIL br_sel got=%0d exp=0", a_fwd); end
    $display("branch-over-stall cnt=%0d", a_cnt);
  endtask

  task automatic test_pc_write();
    do_reset();
    set_instr(PC_REG, 1, 0, 0, 3'b000);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) set_nop();
      #1;
      total++;
      if ({a_stall_f, a_flush_d} !== 2'b11) begin
        bad++; $display("FAIL pcw_c%0d got=%b exp=11", c, {a_stall_f, a_flush_d});
      end
      tick();
    end
    #1;
    total++;
    if ({a_stall_f, a_flush_d} !== 2'b01) begin
      bad++; $display("FAIL pcw_wb got=%b exp=01", {a_stall_f, a_flush_d});
    end
    tick();
    #1;
    total++;
    if (a_flush_d !== 1'b0) begin bad++; $display("FAIL pcw_done got=%b exp=0", a_flush_d); end
    $display("pc-write sequence done");

    do_reset();
    set_instr(PC_REG, 1, 0, 0, 3'b000);
    tick();
    set_nop();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({a_stall_f, a_stall_d, a_flush_d, a_flush_e} !== 4'b0000) begin
      bad++; $display("FAIL pcw_rst got=%b exp=0000", {a_stall_f, a_stall_d, a_flush_d, a_flush_e});
    end

    do_reset();
    set_instr(2, 1, 1, 0, 3'b000);
    tick();
    set_instr(5, 1, 0, 2, 3'b001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (a_stall_d !== 1'b0 || a_cnt !== 32'd0) begin
      bad++; $display("FAIL stall_rst got=%b cnt=%0d exp=0 cnt=0", a_stall_d, a_cnt);
    end
    $display("reset mid-sequence checked");
  endtask

  function automatic int pick_reg();
    int r;
    r = $urandom_range(0, 19);
    return (r == 19) ? PC_REG : (r % 4);
  endfunction

  task automatic test_random();
    rec_t q[$];
    rec_t nq[$];
    rec_t r;
    int src[3];
    int sel[3];
    int efwd[3];
    int ecnt;
    int best;
    int need;
    int wa;
    bit bl;
    bit dv, we, ld, cf, br, rs;
    bit ds, pcp, pcw;
    bit e_sf, e_sd, e_fd, e_fe;
    logic [2:0] used;
    logic [5:0] exp_fwd;

    do_reset();
    ecnt = 0;
    for (int i = 0; i < 3; i++) efwd[i] = 0;

    for (int c = 0; c < 600; c++) begin
      dv   = ($urandom_range(0, 9) < 8);
      we   = ($urandom_range(0, 9) < 7);
      ld   = ($urandom_range(0, 9) < 3);
      wa   = pick_reg();
      for (int i = 0; i < 3; i++) src[i] = pick_reg();
      used = 3'($urandom_range(0, 7));
      cf   = ($urandom_range(0, 9) == 0);
      br   = ($urandom_range(0, 19) == 0);
      rs   = ($urandom_range(0, 49) == 0);

      d_valid        = dv;
      d_src_addr     = {4'(src[2]), 4'(src[1]), 4'(src[0])};
      d_src_used     = used;
      d_wr_en        = we;
      d_wr_addr      = 4'(wa);
      d_is_load      = ld;
      e_cond_fail    = cf;
      branch_taken_e = br;
      rst            = rs;
      #1;

      // Youngest older writer of each operand decides forwarding or waiting.
      ds = 1'b0;
      for (int i = 0; i < 3; i++) begin
        sel[i] = 0;
        best   = 0;
        bl     = 1'b0;
        if (dv && used[i] && src[i] != PC_REG) begin
          foreach (q[j]) begin
            if (q[j].stage < TB_DEPTH && q[j].addr == src[i] && (best == 0 || q[j].stage < best)) begin
              best = q[j].stage;
              bl   = q[j].ld;
            end
          end
          if (best != 0) begin
            need = bl ? TB_LS : 2;
            if (best + 1 >= need) sel[i] = best + 1;
            else ds = 1'b1;
          end
        end
      end
      pcp = dv && we && (wa == PC_REG);
      pcw = 1'b0;
      foreach (q[j]) begin
        if (q[j].addr == PC_REG && q[j].stage < TB_DEPTH) pcp = 1'b1;
        if (q[j].addr == PC_REG && q[j].stage == TB_DEPTH) pcw = 1'b1;
      end
      e_sf = ds | pcp;
      e_sd = ds & ~br;
      e_fe = ds | br;
      e_fd = br | (~ds & (pcp | pcw));
      exp_fwd = {2'(efwd[2]), 2'(efwd[1]), 2'(efwd[0])};

      total++;
      if (a_stall_f !== e_sf) begin bad++; $display("FAIL rnd%0d stall_f got=%b exp=%b", c, a_stall_f, e_sf); end
      total++;
      if (a_stall_d !== e_sd) begin bad++; $display("FAIL rnd%0d stall_d got=%b exp=%b", c, a_stall_d, e_sd); end
      total++;
      if (a_flush_d !== e_fd) begin bad++; $display("FAIL rnd%0d flush_d got=%b exp=%b", c, a_flush_d, e_fd); end
      total++;
      if (a_flush_e !== e_fe) begin bad++; $display("FAIL rnd%0d flush_e got=%b exp=%b", c, a_flush_e, e_fe); end
      total++;
      if (a_fwd !== exp_fwd) begin bad++; $display("FAIL rnd%0d fwd_sel got=%h exp=%h", c, a_fwd, exp_fwd); end
      total++;
      if (a_cnt !== 32'(ecnt)) begin bad++; $display("FAIL rnd%0d count got=%0d exp=%0d", c, a_cnt, ecnt); end
      $display("rnd %0d rst=%0b dv=%0b wr=%0b:%0d ld=%0b src=%0d/%0d/%0d used=%b sf=%0b sd=%0b fd=%0b fe=%0b fwd=%h cnt=%0d",
               c, rs, dv, we, wa, ld, src[0], src[1], src[2], used,
               a_stall_f, a_stall_d, a_flush_d, a_flush_e, a_fwd, a_cnt);

      tick();

      if (rs) begin
        q.delete();
        for (int i = 0; i < 3; i++) efwd[i] = 0;
        ecnt = 0;
      end else begin
        for (int i = 0; i < 3; i++) efwd[i] = e_fe ? 0 : sel[i];
        if (e_sd) ecnt++;
        nq.delete();
        foreach (q[j]) begin
          if (q[j].stage < TB_DEPTH && !(q[j].stage == 1 && cf)) begin
            r = q[j];
            r.stage = r.stage + 1;
            nq.push_back(r);
          end
        end
        if (!e_fe && dv && we) begin
          r.stage = 1;
          r.addr  = wa;
          r.ld    = ld;
          nq.push_back(r);
        end
        q = nq;
      end
    end
    rst            = 1'b0;
    e_cond_fail    = 1'b0;
    branch_taken_e = 1'b0;
    set_nop();
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    e_cond_fail    = 1'b0;
    branch_taken_e = 1'b0;
    set_nop();
    test_reset();
    test_forward();
    test_load_use();
    test_cond_fail();
    test_branch_vs_stall();
    test_pc_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
